stall_sequencer: RTL

- Sits directly downstream of the ID-stage control hazard unit. It consumes that unit's Stall/StallWrite pair plus branch resolution and halt decode.
- Generates the pipeline-register enables and bubble/flush controls for PC, IF/ID and ID/EX.
- Owns the multi-cycle freeze timing: a 2-cycle hazard is guaranteed 2 frozen cycles regardless of what the hazard unit reports mid-stall. The halt lock and a saturating stall-cycle performance counter also live here.

---
 rtl/stall_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/stall_sequencer.sv
// Turns hazard-unit stall requests, branch resolution and halt decode into pipeline enables and flush/bubble controls, with zero latency from inputs to outputs.
// A 2-cycle stall freezes for exactly two cycles; the core locks in halt until reset, and a saturating counter records frozen cycles.
module stall_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall,
  input  logic             StallWrite,
  input  logic             Branch_Taken,
  input  logic             Halt,
  output logic             PC_En,
  output logic             IFID_En,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             Halted,
  output logic [CNT_W-1:0] Stall_Count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD1  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state, nextState;
  logic             freezeNow;
  logic [CNT_W-1:0] stallCount;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stallCount <= '0;
    end else begin
      state <= nextState;
      if (freezeNow && (stallCount != CNT_MAX))
        stallCount <= stallCount + 1'b1;
    end
  end

  always_comb begin
    nextState   = state;
    freezeNow   = 1'b0;
    PC_En       = 1'b1;
    IFID_En     = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    Halted      = 1'b0;

    unique case (state)
      IDLE: begin
        if (Stall) begin
          freezeNow   = 1'b1;
          PC_En       = 1'b0;
          IFID_En     = 1'b0;
          IDEX_Bubble = 1'b1;
          nextState   = StallWrite ? HOLD1 : IDLE;
        end else if (Branch_Taken) begin
          // Branch beats a simultaneous HLT: the HLT is on the wrong path.
          IFID_Flush = 1'b1;
        end else if (Halt) begin
          // HLT itself still advances into EX, so no bubble here.
          PC_En      = 1'b0;
          IFID_En    = 1'b0;
          IFID_Flush = 1'b1;
          nextState  = HALTED;
        end
      end
      HOLD1: begin
        freezeNow   = 1'b1;
        PC_En       = 1'b0;
        IFID_En     = 1'b0;
        IDEX_Bubble = 1'b1;
        nextState   = IDLE;
      end
      HALTED: begin
        PC_En       = 1'b0;
        IFID_En     = 1'b0;
        IDEX_Bubble = 1'b1;
        Halted      = 1'b1;
      end
      default: nextState = IDLE;
    endcase

    if (rst) begin
      freezeNow   = 1'b0;
      PC_En       = 1'b0;
      IFID_En     = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
      Halted      = 1'b0;
    end
  end

  assign Stall_Count = stallCount;

endmodule
